// File: rtl/tile_pixel_writer_if.sv
// ============================================================================
// Module   : tile_pixel_writer_if
// Brief    : Command/pixel/memory-write bundle for the tile pixel writer.
//            Fill signals exist only when TILE_WRITER_FILL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tile_pixel_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_tile;
`ifdef TILE_WRITER_FILL_EN
    logic        cmd_fill;
    logic [23:0] fill_color;
`endif
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pixel;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [23:0] mem_wdata;
    logic        done;
    logic        err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_tile, in_valid, in_pixel,
`ifdef TILE_WRITER_FILL_EN
        output cmd_fill, fill_color,
`endif
        input  cmd_ready, in_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );

    modport slave (
        input  cmd_valid, cmd_tile, in_valid, in_pixel,
`ifdef TILE_WRITER_FILL_EN
        input  cmd_fill, fill_color,
`endif
        output cmd_ready, in_ready, mem_we, mem_addr, mem_wdata, done, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/tile_pixel_writer.sv
// ============================================================================
// Module   : tile_pixel_writer
// Brief    : Writes one TILE_SIZE x TILE_SIZE tile of 24-bit pixels into the
//            tile pixel memory. Optional solid-colour fill: TILE_WRITER_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_pixel_writer #(
    parameter int TILE_SIZE = 10
) (
    input  logic               clk,
    input  logic               rst,
    tile_pixel_writer_if.slave bus
);

    localparam int          CW      = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TILE_SIZE - 1);
    localparam logic [29:0] c_TS    = 30'(TILE_SIZE);
    localparam logic [29:0] c_AREA  = 30'(TILE_SIZE * TILE_SIZE);
    localparam logic [15:0] c_BLANK = 16'hffff;

`ifdef TILE_WRITER_FILL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_FILL = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [29:0]   r_base;
    logic          r_mem_we;
    logic [29:0]   r_mem_addr;
    logic [23:0]   r_mem_wdata;
    logic          r_done;
    logic          r_err;

    logic          w_cmd_xfer;
    logic          w_cmd_ok;
    logic          w_pix_xfer;
    logic          w_step;
    logic          w_x_last;
    logic          w_last;
    logic [23:0]   w_wdata;
    logic [29:0]   w_addr;
    logic [29:0]   w_base;

    assign w_cmd_xfer = bus.cmd_valid && (r_state == ST_IDLE);
    assign w_cmd_ok   = w_cmd_xfer && (bus.cmd_tile != c_BLANK);
    assign w_pix_xfer = bus.in_valid && (r_state == ST_LOAD);
    assign w_x_last   = (r_x == c_LAST);
    assign w_last     = w_x_last && (r_y == c_LAST);

    // Both products are evaluated in a 30-bit context, giving the mod 2^30 wrap.
    assign w_base = c_AREA * 30'(bus.cmd_tile);
    assign w_addr = r_base + 30'(r_y) * c_TS + 30'(r_x);

`ifdef TILE_WRITER_FILL_EN
    logic [23:0] r_fill_color;

    assign w_step  = w_pix_xfer || (r_state == ST_FILL);
    assign w_wdata = (r_state == ST_FILL) ? r_fill_color : bus.in_pixel;
`else
    assign w_step  = w_pix_xfer;
    assign w_wdata = bus.in_pixel;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_ok) begin
`ifdef TILE_WRITER_FILL_EN
                    w_state_next = bus.cmd_fill ? ST_FILL : ST_LOAD;
`else
                    w_state_next = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                if (w_pix_xfer && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
`ifdef TILE_WRITER_FILL_EN
            ST_FILL: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_base      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef TILE_WRITER_FILL_EN
            r_fill_color <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_mem_we <= w_step;
            r_done   <= w_step && w_last;
            r_err    <= w_cmd_xfer && (bus.cmd_tile == c_BLANK);

            if (w_step) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                // Wrap both counters on the final pixel so they stay in range.
                if (w_last) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end

            if (w_cmd_ok) begin
                r_base <= w_base;
                r_x    <= '0;
                r_y    <= '0;
`ifdef TILE_WRITER_FILL_EN
                r_fill_color <= bus.fill_color;
`endif
            end
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

`default_nettype wire
